// File: rtl/router_pkg.sv
// Shared router definitions: flit field layout, TTL seed, encapsulator state encoding, header builder.
// The TRAIL state exists only when ENCAP_CHECKSUM_EN is defined.
package router_pkg;

  localparam int FLIT_W = 64;

  localparam int TTL_LSB = 62;
  localparam int TTL_W   = 2;
  localparam int SRC_LSB = 60;
  localparam int SRC_W   = 2;
  localparam int DST_LSB = 50;
  localparam int DST_W   = 10;
  localparam int HDR_LSB = 41;
  localparam int HDR_W   = 9;
  localparam int SEQ_LSB = 36;
  localparam int SEQ_W   = 5;

  localparam logic [TTL_W-1:0] TTL_INIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_WR,
`ifdef ENCAP_CHECKSUM_EN
    S_TRAIL,
`endif
    S_DONE
  } encap_state_e;

  // Header flit: TTL | src | dst | header info | sequence | zero fill
  function automatic logic [FLIT_W-1:0] build_hdr_flit(
    input logic [SRC_W-1:0] src,
    input logic [DST_W-1:0] dst,
    input logic [HDR_W-1:0] hdr,
    input logic [SEQ_W-1:0] seq
  );
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TTL_LSB +: TTL_W] = TTL_INIT;
    f[SRC_LSB +: SRC_W] = src;
    f[DST_LSB +: DST_W] = dst;
    f[HDR_LSB +: HDR_W] = hdr;
    f[SEQ_LSB +: SEQ_W] = seq;
    return f;
  endfunction

endpackage

// File: rtl/pkt_encap_if.sv
// Encapsulator bus bundle: controller start/parameters, local buffer read port, FIFO write port.
// master = encapsulator side, slave = environment (controller, buffer, FIFO).
interface pkt_encap_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              start_encap_pkt;
  logic [ADDR_W-1:0] router_dst_addr_send;
  logic [8:0]        header_pkt_send;
  logic [ADDR_W-1:0] src_base_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              encap_done;
  logic              busy;

  modport master (
    input  start_encap_pkt, router_dst_addr_send, header_pkt_send, src_base_addr,
    input  mem_rd_data, fifo_full,
    output mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data, encap_done, busy
  );

  modport slave (
    output start_encap_pkt, router_dst_addr_send, header_pkt_send, src_base_addr,
    output mem_rd_data, fifo_full,
    input  mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data, encap_done, busy
  );
endinterface

// File: rtl/pkt_encap.sv
// Frame encapsulator: header flit + NUMBER_PACKET payload flits from the local buffer into FIFO 0.
// Define ENCAP_CHECKSUM_EN to append an XOR-of-payload trailer flit before completion.
module pkt_encap
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = 19,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int SRC_ROUTER_ID          = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  pkt_encap_if.master bus
);

  localparam int IDX_W = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_PACKET - 1);
  localparam logic [RECOGNIZE_ROUTER_WIDTH-1:0] SRC_ID = RECOGNIZE_ROUTER_WIDTH'(SRC_ROUTER_ID);

  encap_state_e state, nxt;

  logic [ADDR_WIDTH-1:0]        dst_q;
  logic [8:0]                   hdr_q;
  logic [ADDR_WIDTH-1:0]        base_q;
  logic [IDX_W-1:0]             idx_q;
  logic [SEQ_W-1:0]             seq_q;
  logic [AURORA_DATA_WIDTH-1:0] hold_q;
`ifdef ENCAP_CHECKSUM_EN
  logic [AURORA_DATA_WIDTH-1:0] cksum_q;
`endif

  logic [AURORA_DATA_WIDTH-1:0] hdr_flit;
  logic                         last;

  assign hdr_flit = AURORA_DATA_WIDTH'(build_hdr_flit(SRC_W'(SRC_ID), DST_W'(dst_q), hdr_q, seq_q));
  assign last     = (idx_q == LAST_IDX);
  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Writes are gated combinationally by fifo_full, so a stalled flit simply
  // holds its state; the buffer is never re-read.
  always_comb begin
    nxt              = state;
    bus.mem_rd_en    = 1'b0;
    bus.mem_rd_addr  = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    bus.encap_done   = 1'b0;
    case (state)
      S_IDLE: if (bus.start_encap_pkt) nxt = S_HDR;
      S_HDR: begin
        bus.fifo_wr_en   = !bus.fifo_full;
        bus.fifo_wr_data = hdr_flit;
        if (!bus.fifo_full) nxt = S_RD;
      end
      S_RD: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = base_q + ADDR_WIDTH'(idx_q);
        nxt             = S_WAIT;
      end
      S_WAIT: nxt = S_WR;
      S_WR: begin
        bus.fifo_wr_en   = !bus.fifo_full;
        bus.fifo_wr_data = hold_q;
        if (!bus.fifo_full) begin
`ifdef ENCAP_CHECKSUM_EN
          nxt = last ? S_TRAIL : S_RD;
`else
          nxt = last ? S_DONE : S_RD;
`endif
        end
      end
`ifdef ENCAP_CHECKSUM_EN
      S_TRAIL: begin
        bus.fifo_wr_en   = !bus.fifo_full;
        bus.fifo_wr_data = cksum_q;
        if (!bus.fifo_full) nxt = S_DONE;
      end
`endif
      S_DONE: begin
        bus.encap_done = 1'b1;
        nxt            = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q   <= '0;
      hdr_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
      hold_q  <= '0;
`ifdef ENCAP_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start_encap_pkt) begin
          dst_q   <= bus.router_dst_addr_send;
          hdr_q   <= bus.header_pkt_send;
          base_q  <= bus.src_base_addr;
          idx_q   <= '0;
`ifdef ENCAP_CHECKSUM_EN
          cksum_q <= '0;
`endif
        end
        S_WAIT: hold_q <= bus.mem_rd_data;
        S_WR: if (!bus.fifo_full) begin
          if (!last) idx_q <= idx_q + IDX_W'(1);
`ifdef ENCAP_CHECKSUM_EN
          cksum_q <= cksum_q ^ hold_q;
`endif
        end
        S_DONE: seq_q <= seq_q + SEQ_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_encap.sv
// Randomized bench for pkt_encap: frames are predicted from the buffer contents and header rules
// and compared against the FIFO write stream, buffer read addresses and completion timing.
module tb_pkt_encap;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int NP = 19;
  localparam int SRC_ID = 0;
`ifdef ENCAP_CHECKSUM_EN
  localparam int DONE_CYC = 60;
`else
  localparam int DONE_CYC = 59;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_encap_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  pkt_encap #(
    .AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUMBER_PACKET(NP),
    .RECOGNIZE_ROUTER_WIDTH(2), .SRC_ROUTER_ID(SRC_ID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [DW-1:0] mem [1024];
  int cyc = 0;
  int t0 = 0;
  int total = 0;
  int bad = 0;
  int exp_seq = 0;

  logic [DW-1:0] wr_q[$];
  int            wr_cyc_q[$];
  logic [AW-1:0] rd_q[$];
  int            done_n = 0;
  int            done_cyc = 0;
  int            viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  always @(negedge clk) begin
    if (bus.fifo_wr_en && bus.fifo_full) viol <= viol + 1;
    if (bus.fifo_wr_en && bus.mem_rd_en) viol <= viol + 1;
    if (bus.fifo_wr_en && !bus.fifo_full) begin
      wr_q.push_back(bus.fifo_wr_data);
      wr_cyc_q.push_back(cyc - t0 + 1);
    end
    if (bus.mem_rd_en) rd_q.push_back(bus.mem_rd_addr);
    if (bus.encap_done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc - t0 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_hdr(input logic [9:0] dst, input logic [8:0] hdr, input int seq);
    return (64'd3 << 62) | (64'(SRC_ID) << 60) | (64'(dst) << 50) | (64'(hdr) << 41)
         | (64'(seq % 32) << 36);
  endfunction

  // Called at posedge+1; the following edge samples start (relative cycle 0).
  task automatic start_frame(input logic [9:0] dst, input logic [8:0] hdr, input logic [9:0] base);
    bus.start_encap_pkt      = 1'b1;
    bus.router_dst_addr_send = dst;
    bus.header_pkt_send      = hdr;
    bus.src_base_addr        = base;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start_encap_pkt = 1'b0;
  endtask

  // bp: 0 none, 1 five-cycle stall on payload 7, 2 random. exp_done <= 0 skips timing check.
  task automatic run_frame(input logic [9:0] dst, input logic [8:0] hdr, input logic [9:0] base,
                           input int bp, input int exp_done);
    logic [63:0] exp_f[$];
    logic [63:0] ck;
    logic [63:0] f;
    int wb, rb, db, n;
    wb = wr_q.size(); rb = rd_q.size(); db = done_n;
    ck = '0;
    exp_f.push_back(model_hdr(dst, hdr, exp_seq));
    for (int k = 0; k < NP; k++) begin
      f = mem[(int'(base) + k) % 1024];
      exp_f.push_back(f);
      ck ^= f;
    end
`ifdef ENCAP_CHECKSUM_EN
    exp_f.push_back(ck);
`endif
    start_frame(dst, hdr, base);
    for (int i = 0; i < 400; i++) begin
      if (done_n != db) break;
      case (bp)
        1: bus.fifo_full = (cyc - t0 >= 24) && (cyc - t0 < 29);
        2: bus.fifo_full = ($urandom_range(0, 3) == 0);
        default: bus.fifo_full = 1'b0;
      endcase
      @(posedge clk); #1;
    end
    bus.fifo_full = 1'b0;
    chk("done_count", 64'(done_n - db), 64'd1);
    n = wr_q.size() - wb;
    chk("flit_count", 64'(n), 64'(exp_f.size()));
    for (int i = 0; i < exp_f.size() && i < n; i++) chk($sformatf("flit%0d", i), wr_q[wb + i], exp_f[i]);
    if (n > 0) begin
      f = wr_q[wb];
      chk("hdr_seq", 64'(f[40:36]), 64'(exp_seq % 32));
    end
    chk("rd_count", 64'(rd_q.size() - rb), 64'(NP));
    for (int k = 0; k < NP && rb + k < rd_q.size(); k++)
      chk($sformatf("rd_addr%0d", k), 64'(rd_q[rb + k]), 64'((int'(base) + k) % 1024));
    if (exp_done > 0) chk("done_cyc", 64'(done_cyc), 64'(exp_done));
    if (bp == 0 && n == exp_f.size()) begin
      chk("hdr_cyc", 64'(wr_cyc_q[wb]), 64'd1);
      for (int k = 0; k < NP; k++) chk($sformatf("pl%0d_cyc", k), 64'(wr_cyc_q[wb + 1 + k]), 64'(4 + 3 * k));
    end
    if (bp == 1 && n > 8) chk("pl7_cyc", 64'(wr_cyc_q[wb + 8]), 64'd30);
    exp_seq = (exp_seq + 1) % 32;
  endtask

  initial begin
    int wcnt, db, i;
    rst_n = 1'b0;
    bus.start_encap_pkt = 1'b0;
    bus.router_dst_addr_send = '0;
    bus.header_pkt_send = '0;
    bus.src_base_addr = '0;
    bus.fifo_full = 1'b0;
    for (int k = 0; k < 1024; k++) mem[k] = 64'(k);
    #2;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_done", 64'(bus.encap_done), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame, stalled frame, address wrap
    run_frame(10'h155, 9'h1A3, 10'h000, 0, DONE_CYC);
    run_frame(10'h155, 9'h1A3, 10'h000, 1, DONE_CYC + 5);
    for (int k = 0; k < 1024; k++) mem[k] = {$urandom, $urandom};
    run_frame(10'($urandom), 9'($urandom), 10'h3F8, 0, DONE_CYC);

    // reset while payload 10 is in flight
    db = done_n;
    wcnt = wr_q.size();
    start_frame(10'h2AA, 9'h055, 10'h100);
    i = 0;
    while (wr_q.size() - wcnt < 11 && i < 200) begin
      @(posedge clk); #1; i++;
    end
    chk("abort_reach", 64'(wr_q.size() - wcnt), 64'd11);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("abort_wr_data", bus.fifo_wr_data, 64'd0);
    chk("abort_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("abort_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
    chk("abort_done", 64'(bus.encap_done), 64'd0);
    wcnt = wr_q.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seq = 0;
    chk("abort_no_done", 64'(done_n - db), 64'd0);
    chk("abort_no_wr", 64'(wr_q.size() - wcnt), 64'd0);

    // 33 back-to-back frames: sequence 0..31 then wraps to 0
    for (int fr = 0; fr < 33; fr++)
      run_frame(10'($urandom), 9'($urandom), 10'($urandom), 0, DONE_CYC);

    // random backpressure
    for (int fr = 0; fr < 4; fr++)
      run_frame(10'($urandom), 9'($urandom), 10'($urandom), 2, 0);

    // one-hot payload: checksum is 19 ones
    for (int k = 0; k < 1024; k++) mem[k] = (k < NP) ? (64'd1 << k) : 64'd0;
    wcnt = wr_q.size();
    run_frame(10'h001, 9'h000, 10'h000, 0, DONE_CYC);
`ifdef ENCAP_CHECKSUM_EN
    if (wr_q.size() - wcnt == NP + 2) chk("trailer", wr_q[wcnt + NP + 1], 64'h7FFFF);
    else chk("trailer_count", 64'(wr_q.size() - wcnt), 64'(NP + 2));
`endif

    chk("protocol_viol", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
